pulse_detect_controller: RTL and testbench

Sequencing controller for the noise-floor threshold detector in the IFM front end. It resets and feeds the detector through a calibration window, latches the resulting threshold and compares the per-sample power stream against it. It declares pulses with time-of-arrival and width, then applies a hold-off before re-arming. It sits between the I/Q power pipeline and the pulse descriptor logic, at 300 MHz.

---
 rtl/pulse_detect_controller.sv | 196 +++++++++++++++++++
 tb/tb_pulse_detect_controller.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_detect_controller.sv
// pulse_detect_controller
// Sequences the noise-floor threshold detector through calibration, latches
// its threshold, then detects pulses in the per-sample power stream,
// reporting time of arrival and width before a hold-off and re-arm.
// Optional build macro: PERIODIC_RECAL_EN adds a timed recalibration request
// that fires after RECAL_PERIOD cycles spent in ARMED.
module pulse_detect_controller #(
  parameter int unsigned CAL_RESET_CYCLES = 4,
  parameter int unsigned CAL_TIMEOUT      = 262143,
  parameter int unsigned MIN_RUN          = 3,
  parameter int unsigned HOLDOFF_CYCLES   = 64
`ifdef PERIODIC_RECAL_EN
  , parameter int unsigned RECAL_PERIOD   = 30000000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        recal_req,
  input  logic [31:0] power,
  input  logic        power_valid,
  input  logic [47:0] threshold,
  input  logic        threshold_calculated,
  output logic        det_reset,
  output logic        det_data_valid,
  output logic        detect,
  output logic        pulse_done,
  output logic [31:0] toa,
  output logic [15:0] pulse_width,
  output logic        cal_err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CAL_RESET = 3'd1,
    S_CAL_RUN   = 3'd2,
    S_ARMED     = 3'd3,
    S_IN_PULSE  = 3'd4,
    S_HOLDOFF   = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  localparam logic [31:0] CAL_RESET_LAST = 32'(CAL_RESET_CYCLES - 1);
  localparam logic [31:0] CAL_TIMEOUT_LAST = 32'(CAL_TIMEOUT - 1);
  localparam logic [31:0] HOLDOFF_LAST = 32'(HOLDOFF_CYCLES - 1);
  localparam logic [15:0] MIN_RUN_W = 16'(MIN_RUN);

  state_t      cur_state, nxt_state;
  logic [31:0] ts;          // free-running timestamp
  logic [31:0] phase_cnt;   // cycles spent in the current state
  logic [15:0] run_cnt;     // consecutive above samples while ARMED
  logic [31:0] run_toa;     // timestamp of the first sample of the run
  logic [47:0] threshold_q;
  logic        pending;     // recalibration requested, not yet started
  logic        periodic_hit;

  logic above, run_hit, fire_detect, fire_done, latch_thr, enter_cal;

  assign state   = cur_state;
  assign above   = power_valid && ({16'b0, power} > threshold_q);
  assign run_hit = above && ((run_cnt + 16'd1) == MIN_RUN_W);
  assign enter_cal = (nxt_state == S_CAL_RESET) && (cur_state != S_CAL_RESET);

`ifdef PERIODIC_RECAL_EN
  localparam logic [31:0] RECAL_LAST = 32'(RECAL_PERIOD - 1);
  logic [31:0] recal_cnt;

  assign periodic_hit = (cur_state == S_ARMED) && (recal_cnt == RECAL_LAST);

  // Count ARMED residency; restart whenever ARMED is (re)entered.
  always_ff @(posedge clk) begin
    if (!reset || cur_state != S_ARMED) recal_cnt <= '0;
    else                                recal_cnt <= recal_cnt + 32'd1;
  end
`else
  assign periodic_hit = 1'b0;
`endif

  // Next-state decode plus detector control and strobe requests.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    nxt_state      = cur_state;
    det_reset      = 1'b1;
    det_data_valid = 1'b0;
    fire_detect    = 1'b0;
    fire_done      = 1'b0;
    latch_thr      = 1'b0;
    case (cur_state)
      S_IDLE: begin
        det_reset = 1'b0;
        if (enable) nxt_state = S_CAL_RESET;
      end
      S_CAL_RESET: begin
        det_reset = 1'b0;
        if (phase_cnt == CAL_RESET_LAST) nxt_state = S_CAL_RUN;
      end
      S_CAL_RUN: begin
        det_data_valid = power_valid;
        // The done flag is ignored on the entry cycle: the detector has only
        // just left reset and may still present a stale flag.
        if (phase_cnt != 32'd0 && threshold_calculated) begin
          latch_thr = 1'b1;
          nxt_state = S_ARMED;
        end else if (phase_cnt == CAL_TIMEOUT_LAST) begin
          nxt_state = S_ERROR;
        end
      end
      S_ARMED: begin
        if (pending) begin
          nxt_state = S_CAL_RESET;
        end else if (run_hit) begin
          fire_detect = 1'b1;
          nxt_state   = S_IN_PULSE;
        end
      end
      S_IN_PULSE: begin
        if (power_valid && !above) begin
          fire_done = 1'b1;
          nxt_state = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (phase_cnt == HOLDOFF_LAST) nxt_state = S_ARMED;
      end
      S_ERROR: det_reset = 1'b0;
      default: nxt_state = S_IDLE;
    endcase
    if (!enable) begin
      nxt_state   = S_IDLE;
      fire_detect = 1'b0;
      fire_done   = 1'b0;
      latch_thr   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; it is not in the
    // sensitivity list, so this is a synchronous reset.
    if (!reset) cur_state <= S_IDLE;
    else        cur_state <= nxt_state;
  end

  // Datapath: timestamp, phase/run counters, threshold latch, reported values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: sequential state is written with <= so every register here
      // samples the pre-edge values, independent of statement order.
      ts          <= '0;
      phase_cnt   <= '0;
      run_cnt     <= '0;
      run_toa     <= '0;
      threshold_q <= '0;
      pending     <= 1'b0;
      detect      <= 1'b0;
      pulse_done  <= 1'b0;
      toa         <= '0;
      pulse_width <= '0;
      cal_err     <= 1'b0;
    end else begin
      ts         <= ts + 32'd1;
      phase_cnt  <= (nxt_state != cur_state) ? 32'd0 : phase_cnt + 32'd1;
      detect     <= fire_detect;
      pulse_done <= fire_done;
      cal_err    <= (nxt_state == S_ERROR);

      if (latch_thr) threshold_q <= threshold;

      // A request arriving on the very cycle calibration starts survives.
      if (enter_cal)                      pending <= recal_req;
      else if (recal_req || periodic_hit) pending <= 1'b1;

      if (cur_state == S_ARMED && nxt_state == S_ARMED) begin
        if (above) begin
          if (run_cnt == 16'd0) run_toa <= ts;
          run_cnt <= run_cnt + 16'd1;
        end else if (power_valid) begin
          run_cnt <= '0;
        end
      end else begin
        run_cnt <= '0;
      end

      if (fire_detect) begin
        toa         <= (run_cnt == 16'd0) ? ts : run_toa;
        pulse_width <= MIN_RUN_W;
      end else if (cur_state == S_IN_PULSE && nxt_state == S_IN_PULSE &&
                   above && pulse_width != 16'hFFFF) begin
        pulse_width <= pulse_width + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_detect_controller.sv
// Testbench for pulse_detect_controller: directed calibration, recalibration,
// abort, reset and timeout scenarios, plus directed and random sample traces
// scored against a trace-level reference model.
module tb_pulse_detect_controller;

  localparam int H    = 64;
  localparam int MR   = 3;
  localparam int CTO  = 300;
  localparam int MAXL = 320;

  logic        clk = 1'b0;
  logic        reset, enable, recal_req, power_valid, threshold_calculated;
  logic [31:0] power;
  logic [47:0] threshold;
  logic        det_reset, det_data_valid, detect, pulse_done, cal_err;
  logic [31:0] toa;
  logic [15:0] pulse_width;
  logic [2:0]  state;

  pulse_detect_controller #(
    .CAL_RESET_CYCLES(4), .CAL_TIMEOUT(CTO), .MIN_RUN(MR), .HOLDOFF_CYCLES(H)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .recal_req(recal_req),
    .power(power), .power_valid(power_valid), .threshold(threshold),
    .threshold_calculated(threshold_calculated), .det_reset(det_reset),
    .det_data_valid(det_data_valid), .detect(detect), .pulse_done(pulse_done),
    .toa(toa), .pulse_width(pulse_width), .cal_err(cal_err), .state(state)
  );

  always #5 clk = ~clk;

  // Reference timestamp: counts every clock, cleared while reset is low.
  logic [31:0] m_ts;
  always @(posedge clk) begin
    if (!reset) m_ts <= '0;
    else        m_ts <= m_ts + 32'd1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(logic v, logic [31:0] p, logic rq);
    power_valid = v;
    power       = p;
    recal_req   = rq;
  endtask

  task automatic wait_state(logic [2:0] s, int budget, string tag);
    int i = 0;
    while (state !== s && i < budget) begin
      tick();
      i++;
    end
    check(tag, 64'(state), 64'(s));
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_state"}, 64'(state), 64'd0);
    check({tag, "_det_reset"}, 64'(det_reset), 64'd0);
    check({tag, "_det_dv"}, 64'(det_data_valid), 64'd0);
    check({tag, "_detect"}, 64'(detect), 64'd0);
    check({tag, "_done"}, 64'(pulse_done), 64'd0);
    check({tag, "_toa"}, 64'(toa), 64'd0);
    check({tag, "_pw"}, 64'(pulse_width), 64'd0);
    check({tag, "_cal_err"}, 64'(cal_err), 64'd0);
  endtask

  // Drives a calibration from IDLE or CAL_RESET; returns in the first ARMED
  // cycle with the threshold input scrambled so only the latched copy matters.
  task automatic calibrate(logic [47:0] thr, int calc_delay);
    int cnt = 0;
    threshold = thr;
    threshold_calculated = 1'b0;
    wait_state(3'd1, 5, "cal_reset_entry");
    while (state === 3'd1 && det_reset === 1'b0 && cnt < 20) begin
      tick();
      cnt++;
    end
    check("cal_reset_len", 64'(cnt), 64'd4);
    check("cal_run_entry", 64'(state), 64'd2);
    for (int i = 0; i < calc_delay; i++) begin
      check("cal_run_det_reset", 64'(det_reset), 64'd1);
      drive(i % 2 == 1, 32'd0, 1'b0);
      #1;
      check("cal_run_dv_fwd", 64'(det_data_valid), 64'(power_valid));
      tick();
    end
    threshold_calculated = 1'b1;
    drive(1'b0, 32'd0, 1'b0);
    tick();
    check("armed_entry", 64'(state), 64'd3);
    threshold_calculated = 1'b0;
    threshold = 48'd0;
  endtask

  // Sample trace presented from an ARMED cycle onward.
  logic        tr_v [MAXL];
  logic [31:0] tr_p [MAXL];
  int          tr_n;

  logic        e_det  [MAXL];
  logic        e_done [MAXL];
  logic [31:0] e_toa  [MAXL];
  logic [15:0] e_pw   [MAXL];
  logic [2:0]  e_st   [MAXL];

  // Reference model: scans the whole trace for runs of MR valid above-threshold
  // samples, pulse extents and hold-off windows, then replays the trace and
  // compares the DUT cycle by cycle.
  task automatic run_trace(logic [47:0] thr, string tag);
    int L, k, run, first, c, term, width;
    logic [31:0] ts0;
    tr_v[tr_n] = 1'b1;
    tr_p[tr_n] = 32'd0;
    for (int i = tr_n + 1; i < tr_n + H + 3; i++) begin
      tr_v[i] = 1'b0;
      tr_p[i] = 32'd0;
    end
    L = tr_n + H + 3;
    for (int i = 0; i < L; i++) begin
      e_det[i] = 1'b0; e_done[i] = 1'b0; e_toa[i] = '0; e_pw[i] = '0; e_st[i] = 3'd3;
    end
    ts0 = m_ts;
    k = 0;
    first = 0;
    while (k < L) begin
      run = 0;
      c = -1;
      for (int j = k; j < L; j++) begin
        e_st[j] = 3'd3;
        if (tr_v[j] && {16'b0, tr_p[j]} > thr) begin
          if (run == 0) first = j;
          run++;
          if (run == MR) begin
            c = j;
            break;
          end
        end else if (tr_v[j]) begin
          run = 0;
        end
      end
      if (c < 0) break;
      e_det[c + 1] = 1'b1;
      e_toa[c + 1] = ts0 + 32'(first);
      width = MR;
      term = -1;
      for (int j = c + 1; j < L; j++) begin
        e_st[j] = 3'd4;
        if (tr_v[j] && {16'b0, tr_p[j]} > thr) begin
          if (width < 65535) width++;
        end else if (tr_v[j]) begin
          term = j;
          break;
        end
      end
      if (term < 0) break;
      e_done[term + 1] = 1'b1;
      e_pw[term + 1] = 16'(width);
      for (int j = term + 1; j <= term + H && j < L; j++) e_st[j] = 3'd5;
      k = term + H + 1;
    end
    for (int i = 0; i < L; i++) begin
      check({tag, "_state"}, 64'(state), 64'(e_st[i]));
      check({tag, "_detect"}, 64'(detect), 64'(e_det[i]));
      check({tag, "_done"}, 64'(pulse_done), 64'(e_done[i]));
      if (e_det[i]) check({tag, "_toa"}, 64'(toa), 64'(e_toa[i]));
      if (e_done[i]) check({tag, "_width"}, 64'(pulse_width), 64'(e_pw[i]));
      drive(tr_v[i], tr_p[i], 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 1'b0);
  endtask

  task automatic gen_random(logic [47:0] thr, int n);
    int sel;
    tr_n = n;
    for (int i = 0; i < n; i++) begin
      tr_v[i] = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       tr_p[i] = 32'(thr) - $urandom_range(1, 50);
        1:       tr_p[i] = 32'(thr);
        default: tr_p[i] = 32'(thr) + $urandom_range(1, 50);
      endcase
    end
  endtask

  task automatic load(logic v[], logic [31:0] p[]);
    tr_n = p.size();
    for (int i = 0; i < tr_n; i++) begin
      tr_v[i] = v[i];
      tr_p[i] = p[i];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b0; enable = 1'b0; recal_req = 1'b0; power_valid = 1'b0;
    power = '0; threshold = '0; threshold_calculated = 1'b0;
    repeat (3) tick();
    check_reset_values("por");

    // Calibration to 1000, then directed detection traces.
    reset = 1'b1;
    enable = 1'b1;
    calibrate(48'd1000, 10);
    load('{1, 1, 1, 1, 1}, '{1001, 1001, 1001, 1001, 500});
    run_trace(48'd1000, "basic");
    load('{1, 1, 1, 1, 1, 1, 1, 1}, '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000});
    run_trace(48'd1000, "equal");
    load('{1, 1, 1, 1, 1, 1}, '{1001, 1001, 500, 1001, 1001, 1001});
    run_trace(48'd1000, "broken_run");
    load('{1, 0, 1, 0, 0, 1}, '{1001, 5000, 1001, 5000, 5000, 1001});
    run_trace(48'd1000, "gaps");
    gen_random(48'd1000, 150);
    run_trace(48'd1000, "rand_a");
    gen_random(48'd1000, 150);
    run_trace(48'd1000, "rand_b");

    // Recalibration requested on the detect cycle: pulse completes first.
    repeat (3) begin
      drive(1'b1, 32'd1001, 1'b0);
      tick();
    end
    check("rp_detect", 64'(detect), 64'd1);
    check("rp_in_pulse", 64'(state), 64'd4);
    drive(1'b1, 32'd1001, 1'b1);
    tick();
    drive(1'b1, 32'd500, 1'b0);
    check("rp_still_pulse", 64'(state), 64'd4);
    tick();
    check("rp_done", 64'(pulse_done), 64'd1);
    check("rp_width", 64'(pulse_width), 64'd4);
    cnt = 0;
    while (state === 3'd5 && cnt < 200) begin
      drive(1'b0, 32'd0, 1'b0);
      tick();
      cnt++;
    end
    check("rp_holdoff_len", 64'(cnt), 64'(H));
    check("rp_armed_once", 64'(state), 64'd3);
    tick();
    check("rp_to_cal_reset", 64'(state), 64'd1);
    calibrate(48'd2000, 3);
    gen_random(48'd2000, 150);
    run_trace(48'd2000, "rand_thr2000");

    // Recalibration requested while ARMED.
    drive(1'b0, 32'd0, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b0);
    check("ra_pending_cycle", 64'(state), 64'd3);
    tick();
    check("ra_cal_reset", 64'(state), 64'd1);
    calibrate(48'd1000, 5);

    // enable dropped mid-pulse: IDLE next cycle, no pulse_done.
    repeat (3) begin
      drive(1'b1, 32'd1001, 1'b0);
      tick();
    end
    check("ab_detect", 64'(detect), 64'd1);
    enable = 1'b0;
    drive(1'b1, 32'd500, 1'b0);
    tick();
    check("ab_idle", 64'(state), 64'd0);
    check("ab_no_done", 64'(pulse_done), 64'd0);
    tick();
    check("ab_no_done_late", 64'(pulse_done), 64'd0);
    enable = 1'b1;
    calibrate(48'd1000, 4);

    // Reset mid-ARMED with a partial run under way.
    drive(1'b1, 32'd1001, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check_reset_values("mid_reset");
    reset = 1'b1;
    drive(1'b0, 32'd0, 1'b0);
    calibrate(48'd1000, 2);
    load('{1, 1, 1, 1, 1}, '{1001, 1001, 1001, 1001, 500});
    run_trace(48'd1000, "post_reset");

    // Calibration timeout.
    enable = 1'b0;
    tick();
    enable = 1'b1;
    wait_state(3'd2, 10, "to_cal_run");
    cnt = 0;
    while (state === 3'd2 && cnt < 1000) begin
      tick();
      cnt++;
    end
    check("to_cal_run_len", 64'(cnt), 64'(CTO));
    check("to_error", 64'(state), 64'd6);
    check("to_cal_err", 64'(cal_err), 64'd1);
    check("to_det_reset", 64'(det_reset), 64'd0);
    repeat (5) tick();
    check("to_cal_err_sticky", 64'(cal_err), 64'd1);
    enable = 1'b0;
    tick();
    check("to_idle", 64'(state), 64'd0);
    check("to_cal_err_clear", 64'(cal_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
